mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 38 +++
 rtl/mem_arbiter_arb_pick.sv | 40 ++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port ids, memory-latency range and the request payload struct.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned MASK_W      = 4;
   localparam int unsigned CNT_W       = 3;
   localparam int unsigned MEM_LAT_MIN = 1;
   localparam int unsigned MEM_LAT_MAX = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_LSU   = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] mask;
      logic              we;
   } mem_req_t;

   // Load value for the WAIT counter; the latency is clamped into its legal range.
   function automatic logic [CNT_W-1:0] wait_load(input int unsigned lat);
      int unsigned l;
      l = lat;
      if (l < MEM_LAT_MIN) l = MEM_LAT_MIN;
      if (l > MEM_LAT_MAX) l = MEM_LAT_MAX;
      return CNT_W'(l - 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner select between the fetch (0) and load/store (1) requesters.
// Build option ARB_ROUND_ROBIN_EN: when defined, simultaneous requests go to
// the port not granted last; otherwise port 1 always wins and 'last' is ignored.
// Ports:
//   req0, req1 : request lines
//   last       : port id granted most recently
//   grant      : winning port id (combinational, meaningful when any req is high)
module arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant
);

`ifdef ARB_ROUND_ROBIN_EN
   // Alternate on contention, otherwise serve whichever port is asking.
   always_comb begin
      grant = PORT_FETCH;
      if (req0 && req1) begin
         grant = ~last;
      end else if (req1) begin
         grant = PORT_LSU;
      end
   end
`else
   // Fixed priority: load/store beats fetch.
   logic unused_last;
   assign unused_last = last;

   always_comb begin
      grant = PORT_FETCH;
      if (req1) begin
         grant = PORT_LSU;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous memory.
// FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; writes go ISSUE -> RESP.
// Build option ARB_ROUND_ROBIN_EN selects round-robin instead of port-1 priority.
// Parameter MEM_LAT (1..7): cycles from the O_mem_en cycle to valid I_mem_data.
// Ports:
//   I_clk, I_rst_n          : clock, async active-low reset
//   I_reqN/addrN/dataN/maskN/weN : requester N (0 = fetch, 1 = load/store)
//   O_ackN, O_dataN         : one-cycle completion pulse and read data
//   O_mem_*                 : shared memory command, I_mem_data read return
//   O_busy                  : high whenever the FSM is not IDLE
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              I_clk,
   input  logic              I_rst_n,
   input  logic              I_req0,
   input  logic              I_req1,
   input  logic [ADDR_W-1:0] I_addr0,
   input  logic [ADDR_W-1:0] I_addr1,
   input  logic [DATA_W-1:0] I_data0,
   input  logic [DATA_W-1:0] I_data1,
   input  logic [MASK_W-1:0] I_mask0,
   input  logic [MASK_W-1:0] I_mask1,
   input  logic              I_we0,
   input  logic              I_we1,
   output logic              O_ack0,
   output logic              O_ack1,
   output logic [DATA_W-1:0] O_data0,
   output logic [DATA_W-1:0] O_data1,
   output logic [ADDR_W-1:0] O_mem_addr,
   output logic [DATA_W-1:0] O_mem_data,
   output logic [MASK_W-1:0] O_mem_mask,
   output logic              O_mem_we,
   output logic              O_mem_en,
   input  logic [DATA_W-1:0] I_mem_data,
   output logic              O_busy
);

   state_t           state;
   logic             grant_c;
   logic             last_grant;
   logic             lat_we;
   logic             lat_port;
   logic [CNT_W-1:0] wait_cnt;
   mem_req_t         req_sel_c;

   arb_pick u_pick (
      .req0  (I_req0),
      .req1  (I_req1),
      .last  (last_grant),
      .grant (grant_c)
   );

`ifdef ARB_ROUND_ROBIN_EN
   // Pointer moves only when a grant is actually made; reset favours port 0.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         last_grant <= PORT_LSU;
      end else if (state == IDLE && (I_req0 || I_req1)) begin
         last_grant <= grant_c;
      end
   end
`else
   assign last_grant = PORT_LSU;
`endif

   // Payload of the winning requester.
   always_comb begin
      req_sel_c.addr = I_addr0;
      req_sel_c.data = I_data0;
      req_sel_c.mask = I_mask0;
      req_sel_c.we   = I_we0;
      if (grant_c == PORT_LSU) begin
         req_sel_c.addr = I_addr1;
         req_sel_c.data = I_data1;
         req_sel_c.mask = I_mask1;
         req_sel_c.we   = I_we1;
      end
   end

   // Arbiter FSM with registered outputs. O_mem_addr/data/mask double as the
   // latched request and hold between accesses. Reads dwell MEM_LAT cycles in
   // WAIT so the capture edge lands MEM_LAT edges after the edge that closes ISSUE.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state      <= IDLE;
         lat_we     <= 1'b0;
         lat_port   <= PORT_FETCH;
         wait_cnt   <= '0;
         O_ack0     <= 1'b0;
         O_ack1     <= 1'b0;
         O_data0    <= '0;
         O_data1    <= '0;
         O_mem_addr <= '0;
         O_mem_data <= '0;
         O_mem_mask <= '0;
         O_mem_we   <= 1'b0;
         O_mem_en   <= 1'b0;
         O_busy     <= 1'b0;
      end else begin
         O_ack0   <= 1'b0;
         O_ack1   <= 1'b0;
         O_mem_en <= 1'b0;
         O_mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (I_req0 || I_req1) begin
                  state      <= ISSUE;
                  lat_we     <= req_sel_c.we;
                  lat_port   <= grant_c;
                  O_mem_addr <= req_sel_c.addr;
                  O_mem_data <= req_sel_c.data;
                  O_mem_mask <= req_sel_c.mask;
                  O_mem_we   <= req_sel_c.we;
                  O_mem_en   <= 1'b1;
                  O_busy     <= 1'b1;
               end
            end
            ISSUE: begin
               if (lat_we) begin
                  state  <= RESP;
                  O_ack0 <= (lat_port == PORT_FETCH);
                  O_ack1 <= (lat_port == PORT_LSU);
               end else begin
                  state    <= WAIT;
                  wait_cnt <= wait_load(MEM_LAT);
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  state <= RESP;
                  if (lat_port == PORT_LSU) begin
                     O_data1 <= I_mem_data;
                     O_ack1  <= 1'b1;
                  end else begin
                     O_data0 <= I_mem_data;
                     O_ack0  <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            RESP: begin
               state  <= IDLE;
               O_busy <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               O_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance 0 uses MEM_LAT=1, instance 1 MEM_LAT=4.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req0 [2], req1 [2], we0 [2], we1 [2];
   logic [31:0] addr0 [2], addr1 [2], data0 [2], data1 [2];
   logic [3:0]  mask0 [2], mask1 [2];
   logic        ack0 [2], ack1 [2], mem_we [2], mem_en [2], busy [2];
   logic [31:0] odata0 [2], odata1 [2], mem_addr [2], mem_wdata [2];
   logic [3:0]  mem_mask [2];

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   int          ack_n, clash_n, ack_cyc, a0_cyc, a1_cyc;

   // Memory contents seen by reads.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h40) return 32'h1234_5678;
      return {a[15:0], 16'hC0DE};
   endfunction

   // Port expected to win the k-th grant when both requesters are held.
   function automatic logic exp_port(input int k);
`ifdef ARB_ROUND_ROBIN_EN
      return (k == 4) ? 1'b0 : 1'(k % 2);
`else
      return (k == 4) ? 1'b0 : 1'b1;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 1 : 4;
      logic [2:0]  cnt  = '0;
      logic [31:0] pend = '0;
      logic [31:0] rdata;

      mem_arbiter #(.MEM_LAT(LAT)) u_dut (
         .I_clk      (clk),
         .I_rst_n    (rst_n),
         .I_req0     (req0[g]),
         .I_req1     (req1[g]),
         .I_addr0    (addr0[g]),
         .I_addr1    (addr1[g]),
         .I_data0    (data0[g]),
         .I_data1    (data1[g]),
         .I_mask0    (mask0[g]),
         .I_mask1    (mask1[g]),
         .I_we0      (we0[g]),
         .I_we1      (we1[g]),
         .O_ack0     (ack0[g]),
         .O_ack1     (ack1[g]),
         .O_data0    (odata0[g]),
         .O_data1    (odata1[g]),
         .O_mem_addr (mem_addr[g]),
         .O_mem_data (mem_wdata[g]),
         .O_mem_mask (mem_mask[g]),
         .O_mem_we   (mem_we[g]),
         .O_mem_en   (mem_en[g]),
         .I_mem_data (rdata),
         .O_busy     (busy[g])
      );

      // Synchronous memory: read data valid only in the cycle LAT cycles after the en cycle.
      always @(posedge clk) begin
         if (mem_en[g] && !mem_we[g]) begin
            cnt  <= 3'(LAT);
            pend <= mem_val(mem_addr[g]);
         end else if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
         end
      end
      assign rdata = (cnt == 3'd1) ? pend : 32'hDEAD_BEEF;
   end

   // One request on port p of instance d, started just after a rising edge.
   task automatic txn(input int d, input bit p, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] m, input int exp_cyc,
                      input string tag);
      int          t_ack = -1;
      int          en_cnt = 0;
      int          en_cyc = -1;
      int          clash = 0;
      int          busy_bad = 0;
      logic [31:0] own_prev, oth_prev, own_now, oth_now;
      own_prev = p ? odata1[d] : odata0[d];
      oth_prev = p ? odata0[d] : odata1[d];
      if (p) begin
         req1[d] = 1'b1; we1[d] = we; addr1[d] = a; data1[d] = wd; mask1[d] = m;
      end else begin
         req0[d] = 1'b1; we0[d] = we; addr0[d] = a; data0[d] = wd; mask0[d] = m;
      end
      for (int cyc = 0; cyc <= 20 && t_ack < 0; cyc++) begin
         @(negedge clk);
         if (mem_en[d]) begin
            en_cnt++;
            if (en_cyc < 0) begin
               en_cyc = cyc;
               check({tag, "_mem_addr"}, mem_addr[d], a);
               check({tag, "_mem_we"}, 32'(mem_we[d]), 32'(we));
               if (we) begin
                  check({tag, "_mem_data"}, mem_wdata[d], wd);
                  check({tag, "_mem_mask"}, 32'(mem_mask[d]), 32'(m));
               end
            end
         end
         if (busy[d] !== (cyc >= 1)) busy_bad++;
         if ((p ? ack1[d] : ack0[d]) === 1'b1) t_ack = cyc;
         if ((p ? ack0[d] : ack1[d]) === 1'b1) clash++;
      end
      own_now = p ? odata1[d] : odata0[d];
      oth_now = p ? odata0[d] : odata1[d];
      check({tag, "_ack_cycle"}, 32'(t_ack), 32'(exp_cyc));
      check({tag, "_en_cycle"}, 32'(en_cyc), 32'd1);
      check({tag, "_en_pulses"}, 32'(en_cnt), 32'd1);
      check({tag, "_own_data"}, own_now, we ? own_prev : mem_val(a));
      check({tag, "_other_data"}, oth_now, oth_prev);
      check({tag, "_other_ack"}, 32'(clash), 32'd0);
      check({tag, "_busy"}, 32'(busy_bad), 32'd0);
      @(posedge clk); #1;
      if (p) req1[d] = 1'b0;
      else   req0[d] = 1'b0;
      @(negedge clk);
      check({tag, "_after_ack"}, {30'd0, ack0[d], ack1[d]}, 32'd0);
      check({tag, "_after_busy"}, 32'(busy[d]), 32'd0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         req0[d] = 1'b0; req1[d] = 1'b0; we0[d] = 1'b0; we1[d] = 1'b0;
         addr0[d] = '0; addr1[d] = '0; data0[d] = '0; data1[d] = '0;
         mask0[d] = '0; mask1[d] = '0;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 32'(busy[0]), 32'd0);
      check("reset_acks", {30'd0, ack0[0], ack1[0]}, 32'd0);
      check("reset_en_we", {30'd0, mem_en[0], mem_we[0]}, 32'd0);
      check("reset_mem_addr", mem_addr[0], 32'd0);
      check("reset_data0", odata0[0], 32'd0);
      check("reset_mask", 32'(mem_mask[0]), 32'd0);
      rst_n = 1'b1;

      @(posedge clk); #1;
      txn(0, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 3, "rd_lat1");
      @(posedge clk); #1;
      txn(0, 1'b1, 1'b1, 32'h80, 32'hAABB_CCDD, 4'b0011, 2, "wr_p1");
      @(posedge clk); #1;
      txn(1, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 6, "rd_lat4");

      // Both requesters held on instance 0.
      @(posedge clk); #1;
      req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 32'h200;
      req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 32'h300;
      ack_n = 0; clash_n = 0;
      for (int cyc = 0; cyc < 40 && ack_n < 5; cyc++) begin
         @(negedge clk);
         if (ack0[0] && ack1[0]) begin
            clash_n++;
         end else if (ack0[0] || ack1[0]) begin
            check($sformatf("both_port%0d", ack_n), 32'(ack1[0]), 32'(exp_port(ack_n)));
            check($sformatf("both_cycle%0d", ack_n), 32'(cyc), 32'(3 + 4 * ack_n));
            check($sformatf("both_data%0d", ack_n),
                  exp_port(ack_n) ? odata1[0] : odata0[0],
                  exp_port(ack_n) ? mem_val(32'h300) : mem_val(32'h200));
            ack_n++;
            if (ack_n == 4) begin
               @(posedge clk); #1;
               req1[0] = 1'b0;
            end
         end
      end
      check("both_ack_count", 32'(ack_n), 32'd5);
      check("both_clash", 32'(clash_n), 32'd0);
      @(posedge clk); #1;
      req0[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset asserted while a read sits in WAIT, request held through release.
      req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 32'h44;
      repeat (3) @(negedge clk);
      check("rst_pre_busy", 32'(busy[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy[0]), 32'd0);
      check("rst_acks", {30'd0, ack0[0], ack1[0]}, 32'd0);
      check("rst_en_we", {30'd0, mem_en[0], mem_we[0]}, 32'd0);
      check("rst_mem_addr", mem_addr[0], 32'd0);
      check("rst_data0", odata0[0], 32'd0);
      check("rst_data1", odata1[0], 32'd0);
      clash_n = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (ack0[0] || ack1[0] || busy[0]) clash_n++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      ack_cyc = -1;
      for (int cyc = 1; cyc <= 10 && ack_cyc < 0; cyc++) begin
         @(negedge clk);
         if (ack0[0]) ack_cyc = cyc;
         if (ack1[0]) clash_n++;
      end
      check("rst_quiet", 32'(clash_n), 32'd0);
      check("rst_regrant_cycle", 32'(ack_cyc), 32'd3);
      check("rst_regrant_data", odata0[0], mem_val(32'h44));
      @(posedge clk); #1;
      req0[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Port 1 wins, drops its request in WAIT; port 0 is served next.
      req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 32'h48;
      req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 32'h88;
      a0_cyc = -1; a1_cyc = -1; clash_n = 0;
      for (int cyc = 0; cyc <= 20 && a0_cyc < 0; cyc++) begin
         @(negedge clk);
         if (cyc == 1) check("drop_mem_addr1", mem_addr[0], 32'h88);
         if (cyc == 5) begin
            check("drop_mem_addr0", mem_addr[0], 32'h48);
            check("drop_mem_en0", 32'(mem_en[0]), 32'd1);
         end
         if (ack0[0] && ack1[0]) clash_n++;
         if (ack1[0]) begin
            a1_cyc = cyc;
            check("drop_data1", odata1[0], mem_val(32'h88));
         end
         if (ack0[0]) begin
            a0_cyc = cyc;
            check("drop_data0", odata0[0], mem_val(32'h48));
         end
         if (cyc == 1) begin
            @(posedge clk); #1;
            req1[0] = 1'b0;
         end
      end
      check("drop_ack1_cycle", 32'(a1_cyc), 32'd3);
      check("drop_ack0_cycle", 32'(a0_cyc), 32'd7);
      check("drop_clash", 32'(clash_n), 32'd0);
      @(posedge clk); #1;
      req0[0] = 1'b0;
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
